// File: rtl/add_approx_pipe.sv
// Segmented pipelined unsigned adder with optional lower-part-OR approximation
// on the low APPROX_BITS bits and a saturating count of approximation errors.
module add_approx_pipe #(
  parameter int WIDTH       = 8,
  parameter int SEG         = 4,
  parameter int APPROX_BITS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   o,
  output logic             out_approx,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int          NSTG    = WIDTH / SEG;
  localparam int          LI      = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
  localparam bit          APX_ON  = (APPROX_BITS > 0);
  localparam logic [SEG:0] LO_MASK = (SEG + 1)'((1 << APPROX_BITS) - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NSTG-1:0]            vld_q, vld_d, cy_q, cy_d, apx_q, apx_d, err_q, err_d;
  logic [NSTG-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNT_W-1:0]           err_cnt_q, err_cnt_d;
  logic [SEG:0]               a_seg, b_seg, lo_or, exact0, approx0, s0, seg_sum;
  logic                       loa_c, use_apx, lo_mismatch, en, out_hs;
  logic                       unused_ops;

  assign en         = !vld_q[NSTG-1] || out_ready;
  assign in_ready   = en;
  assign out_hs     = vld_q[NSTG-1] && out_ready;
  assign out_valid  = vld_q[NSTG-1];
  assign o          = {cy_q[NSTG-1], sum_q[NSTG-1]};
  assign out_approx = apx_q[NSTG-1];
  assign err_cnt    = err_cnt_q;
  // Last stage no longer needs its operand copies.
  assign unused_ops = ^{a_q[NSTG-1], b_q[NSTG-1]};

  always_comb begin
    vld_d   = '0;
    cy_d    = '0;
    apx_d   = '0;
    err_d   = '0;
    a_d     = '0;
    b_d     = '0;
    sum_d   = '0;
    seg_sum = '0;

    // Stage 0: segment 0, either exact or with an OR'd low part and LOA carry.
    a_seg       = {1'b0, a[SEG-1:0]};
    b_seg       = {1'b0, b[SEG-1:0]};
    lo_or       = (a_seg | b_seg) & LO_MASK;
    loa_c       = a[LI] & b[LI];
    use_apx     = approx_en && APX_ON;
    exact0      = a_seg + b_seg;
    approx0     = (((a_seg >> APPROX_BITS) + (b_seg >> APPROX_BITS) + (SEG + 1)'(loa_c))
                   << APPROX_BITS) | lo_or;
    lo_mismatch = (lo_or + ((SEG + 1)'(loa_c) << APPROX_BITS))
                  != ((a_seg & LO_MASK) + (b_seg & LO_MASK));
    s0          = use_apx ? approx0 : exact0;

    vld_d[0]           = in_valid;
    a_d[0]             = a;
    b_d[0]             = b;
    apx_d[0]           = approx_en;
    err_d[0]           = use_apx && lo_mismatch;
    sum_d[0][SEG-1:0]  = s0[SEG-1:0];
    cy_d[0]            = s0[SEG];

    // Stages 1..NSTG-1: next segment plus the registered carry.
    for (int k = 1; k < NSTG; k++) begin
      seg_sum  = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
                 + (SEG + 1)'(cy_q[k-1]);
      vld_d[k] = vld_q[k-1];
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      apx_d[k] = apx_q[k-1];
      err_d[k] = err_q[k-1];
      sum_d[k] = sum_q[k-1];
      sum_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      cy_d[k]  = seg_sum[SEG];
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (out_hs && err_q[NSTG-1]) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // Whole pipe advances together; a stalled output freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      apx_q <= '0;
      err_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else if (en) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      apx_q <= apx_d;
      err_q <= err_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_add_approx_pipe.sv
// Scoreboard bench for add_approx_pipe (WIDTH=8, SEG=4, APPROX_BITS=2, CNT_W=2).
module tb_add_approx_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       approx_en = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [8:0] o;
  logic       out_approx;
  logic [1:0] err_cnt;
  logic       err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [8:0] o;
    logic       apx;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] seen[$];
  logic [1:0] exp_cnt = '0;

  add_approx_pipe #(.WIDTH(8), .SEG(4), .APPROX_BITS(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .o(o), .out_approx(out_approx),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: exact sum, or OR'd low 2 bits with carry a[1]&b[1] into bit 2.
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic ap);
    exp_t       r;
    logic       c;
    logic [6:0] hi;
    logic [1:0] lo;
    r.apx = ap;
    r.err = 1'b0;
    if (!ap) begin
      r.o = {1'b0, av} + {1'b0, bv};
    end else begin
      lo    = av[1:0] | bv[1:0];
      c     = av[1] & bv[1];
      hi    = {1'b0, av[7:2]} + {1'b0, bv[7:2]} + {6'd0, c};
      r.o   = {hi, lo};
      r.err = ({1'b0, lo} + {c, 2'b00}) != ({1'b0, av[1:0]} + {1'b0, bv[1:0]});
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
      sb.delete();
      exp_cnt = '0;
    end else begin
      chk("err_cnt", {30'd0, err_cnt}, {30'd0, exp_cnt});
      e.err = 1'b0;
      if (out_valid && out_ready) begin
        seen.push_back(o);
        if (sb.size() == 0) begin
          chk("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("o", {23'd0, o}, {23'd0, e.o});
          chk("out_approx", {31'd0, out_approx}, {31'd0, e.apx});
        end
      end
      if (err_clr) exp_cnt = '0;
      else if (out_valid && out_ready && e.err && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      if (in_valid && in_ready) sb.push_back(model(a, b, approx_en));
    end
  end

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic ap);
    bit got = 1'b0;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    approx_en = ap;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    int t4_exp[4] = '{2, 4, 6, 8};
    #1;
    chk("rst_o", {23'd0, o}, 32'd0);
    chk("rst_out_approx", {31'd0, out_approx}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: exact with carry-out, latency check
    send(8'hFF, 8'h01, 1'b0);
    chk("t1_not_yet", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_o", {23'd0, o}, 32'h100);
    chk("t1_apx", {31'd0, out_approx}, 32'd0);
    chk("t1_err_cnt", {30'd0, err_cnt}, 32'd0);
    drain();

    // 2: approximate with error
    send(8'h03, 8'h01, 1'b1);
    wait_out("t2_valid");
    chk("t2_o", {23'd0, o}, 32'h003);
    chk("t2_apx", {31'd0, out_approx}, 32'd1);
    @(posedge clk);
    #1;
    chk("t2_err_cnt", {30'd0, err_cnt}, 32'd1);

    // 3: approximate without error
    send(8'h0A, 8'h05, 1'b1);
    wait_out("t3_valid");
    chk("t3_o", {23'd0, o}, 32'h00F);
    @(posedge clk);
    #1;
    chk("t3_err_cnt", {30'd0, err_cnt}, 32'd1);

    // 4: backpressure
    seen.delete();
    fork
      begin
        for (int i = 1; i <= 4; i++) send(8'(i), 8'(i), 1'b0);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          #1;
          if (out_valid) break;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t4_stall_in_ready", {31'd0, in_ready}, 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_count", seen.size(), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("t4_order", {23'd0, seen[i]}, t4_exp[i]);

    // 5: saturation then clear colliding with an error handshake
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h03, 8'h01, 1'b1);
    drain();
    chk("t5_sat", {30'd0, err_cnt}, 32'd3);
    send(8'h03, 8'h01, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("t5_clear_wins", {30'd0, err_cnt}, 32'd0);

    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      begin
        for (int i = 0; i < 80; i++) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // 6: reset with two transactions in flight
    out_ready = 1'b0;
    send(8'h05, 8'h06, 1'b0);
    send(8'h07, 8'h08, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_o", {23'd0, o}, 32'd0);
    chk("t6_err_cnt", {30'd0, err_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    seen.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_stale", seen.size(), 32'd0);
    send(8'h10, 8'h20, 1'b0);
    drain();
    chk("t6_fresh_count", seen.size(), 32'd1);

    chk("final_sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
